// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller. A single 1-bit full adder cell
// is time-shared over WIDTH clocks and adds two operands LSB first. The
// requester sees a start/busy/done handshake. The result and the carry-out are
// held until the next operation completes.

// Single-bit full adder. This is the only arithmetic resource in the block.
module full_adder_join (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic SUM,
  output logic COUT
);

  assign SUM  = A ^ B ^ C;
  assign COUT = (A & B) | (A & C) | (B & C);

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   res_sh;
  logic [WIDTH-1:0]   res_next;
  logic               carry;
  logic [CNT_W-1:0]   count;
  logic               last_bit;

  logic               fa_sum;
  logic               fa_cout;

  // The one shared adder cell. It always sees the current LSBs and the running carry.
  full_adder_join u_fa (
    .A    (op_a[0]),
    .B    (op_b[0]),
    .C    (carry),
    .SUM  (fa_sum),
    .COUT (fa_cout)
  );

  // The edge that processes bit WIDTH-1 ends the operation.
  assign last_bit = (count == CNT_W'(WIDTH - 1));

  // Result shift register input. The new sum bit enters at the MSB, so after
  // WIDTH shifts bit 0 of the sum sits at bit 0 of the register.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = fa_sum;
    end else begin : g_res_wn
      assign res_next = {fa_sum, res_sh[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  // NOTE: asynchronous active-low reset. rst_n appears in the sensitivity list,
  // so an operation in flight is aborted without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // register then updates from values sampled before the edge.
      state <= state_next;
    end
  end

  // Next-state logic. busy and done are decoded from the registered state only.
  always_comb begin
    // NOTE: defaults are assigned before the case. Every path then drives every
    // output, and no latch is inferred.
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, serial shifting, and result commit on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a     <= '0;
      op_b     <= '0;
      res_sh   <= '0;
      carry    <= 1'b0;
      count    <= '0;
      sum_out  <= '0;
      cout_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_a   <= a_in;
            op_b   <= b_in;
            carry  <= cin;
            count  <= '0;
            res_sh <= '0;
          end
        end
        RUN: begin
          op_a   <= op_a >> 1;
          op_b   <= op_b >> 1;
          res_sh <= res_next;
          carry  <= fa_cout;
          if (last_bit) begin
            // The visible result moves only here. During RUN the previous
            // result stays stable on sum_out and cout_out.
            sum_out  <= res_next;
            cout_out <= fa_cout;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
